// File: rtl/chimp_pkg.sv
// Shared constants and types for the chimp board grid hit-tester.
// Grid geometry defaults and the click FSM state encoding.
package chimp_pkg;

  localparam int DEF_N_COLS  = 8;
  localparam int DEF_N_ROWS  = 8;
  localparam int DEF_CELL_X0 = 17;
  localparam int DEF_CELL_Y0 = 8;
  localparam int DEF_CELL_W  = 20;
  localparam int DEF_CELL_H  = 20;
  localparam int DEF_X_PITCH = 37;
  localparam int DEF_Y_PITCH = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2
  } click_st_e;

endpackage

// File: rtl/grid_axis_hit.sv
// One-axis cell hit test over N equally pitched spans.
// Unrolled comparator chain; the lowest matching index wins.
module grid_axis_hit #(
  parameter  int N      = 8,
  parameter  int W      = 10,
  parameter  int ORIGIN = 17,
  parameter  int SPAN   = 20,
  parameter  int PITCH  = 37,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0]  coord,
  output logic [IW-1:0] idx,
  output logic          hit
);

  logic [31:0] c;
  assign c = 32'(coord);

  // scan high to low so the lowest matching cell ends up selected
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (c >= 32'(ORIGIN + k * PITCH) &&
          c <= 32'(ORIGIN + k * PITCH + SPAN - 1)) begin
        idx = IW'(k);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chimp_grid_click.sv
// Grid hit-tester and click qualifier for the chimp test board.
// Two pipeline stages feed a registered-output click FSM.
module chimp_grid_click
  import chimp_pkg::*;
#(
  parameter  int N_COLS       = DEF_N_COLS,
  parameter  int N_ROWS       = DEF_N_ROWS,
  parameter  int X_W          = 10,
  parameter  int Y_W          = 9,
  parameter  int CELL_X0      = DEF_CELL_X0,
  parameter  int CELL_Y0      = DEF_CELL_Y0,
  parameter  int CELL_W       = DEF_CELL_W,
  parameter  int CELL_H       = DEF_CELL_H,
  parameter  int X_PITCH      = DEF_X_PITCH,
  parameter  int Y_PITCH      = DEF_Y_PITCH,
  parameter  int RELEASE_MODE = 0,
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1,
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic          clk,
  input  logic          iReset,
  input  logic          iEnable,
  input  logic [X_W-1:0] iMouseX,
  input  logic [Y_W-1:0] iMouseY,
  input  logic          iButton,
  output logic          oHoverValid,
  output logic [CW-1:0] oHoverCol,
  output logic [RW-1:0] oHoverRow,
  output logic          oClick,
  output logic [CW-1:0] oClickCol,
  output logic [RW-1:0] oClickRow,
  output logic          oMiss,
  output logic          oCancel,
  output logic          oBusy
);

  logic [X_W-1:0] x_a;
  logic [Y_W-1:0] y_a;
  logic           btn_a, btn_p;

  logic [CW-1:0]  col_i;
  logic [RW-1:0]  row_i;
  logic           col_hit, row_hit;

  logic           valid_b, rise_b, fall_b;
  logic [CW-1:0]  col_b;
  logic [RW-1:0]  row_b;

  click_st_e      st_q, st_d;
  logic           click_d, miss_d, cancel_d;
  logic [CW-1:0]  ccol_d, lcol_q, lcol_d;
  logic [RW-1:0]  crow_d, lrow_q, lrow_d;

  grid_axis_hit #(
    .N(N_COLS), .W(X_W), .ORIGIN(CELL_X0),
    .SPAN(CELL_W), .PITCH(X_PITCH)
  ) u_xhit (
    .coord(x_a), .idx(col_i), .hit(col_hit)
  );

  grid_axis_hit #(
    .N(N_ROWS), .W(Y_W), .ORIGIN(CELL_Y0),
    .SPAN(CELL_H), .PITCH(Y_PITCH)
  ) u_yhit (
    .coord(y_a), .idx(row_i), .hit(row_hit)
  );

  // stage A: register cursor and button, keep last button sample
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      x_a   <= '0;
      y_a   <= '0;
      btn_a <= 1'b0;
      btn_p <= 1'b0;
    end else begin
      x_a   <= iMouseX;
      y_a   <= iMouseY;
      btn_a <= iButton;
      btn_p <= btn_a;
    end
  end

  // stage B: register cell indices, validity and button edges
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      valid_b <= 1'b0;
      col_b   <= '0;
      row_b   <= '0;
      rise_b  <= 1'b0;
      fall_b  <= 1'b0;
    end else begin
      valid_b <= col_hit & row_hit;
      col_b   <= (col_hit & row_hit) ? col_i : '0;
      row_b   <= (col_hit & row_hit) ? row_i : '0;
      rise_b  <= btn_a & ~btn_p;
      fall_b  <= ~btn_a & btn_p;
    end
  end

  assign oHoverValid = valid_b;
  assign oHoverCol   = col_b;
  assign oHoverRow   = row_b;
  assign oBusy       = (st_q != IDLE);

  // click FSM: next state and next pulse/index values
  always_comb begin
    st_d     = st_q;
    click_d  = 1'b0;
    miss_d   = 1'b0;
    cancel_d = 1'b0;
    ccol_d   = oClickCol;
    crow_d   = oClickRow;
    lcol_d   = lcol_q;
    lrow_d   = lrow_q;
    unique case (st_q)
      IDLE: begin
        if (rise_b && iEnable) begin
          if (!valid_b) begin
            miss_d = 1'b1;
            st_d   = HELD;
          end else if (RELEASE_MODE != 0) begin
            lcol_d = col_b;
            lrow_d = row_b;
            st_d   = ARMED;
          end else begin
            click_d = 1'b1;
            ccol_d  = col_b;
            crow_d  = row_b;
            st_d    = HELD;
          end
        end
      end
      ARMED: begin
        if (fall_b) begin
          st_d = IDLE;
          if (valid_b && col_b == lcol_q &&
              row_b == lrow_q) begin
            click_d = 1'b1;
            ccol_d  = lcol_q;
            crow_d  = lrow_q;
          end else begin
            cancel_d = 1'b1;
          end
        end
      end
      HELD: begin
        if (fall_b) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // click FSM: state and registered outputs
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      st_q      <= IDLE;
      oClick    <= 1'b0;
      oMiss     <= 1'b0;
      oCancel   <= 1'b0;
      oClickCol <= '0;
      oClickRow <= '0;
      lcol_q    <= '0;
      lrow_q    <= '0;
    end else begin
      st_q      <= st_d;
      oClick    <= click_d;
      oMiss     <= miss_d;
      oCancel   <= cancel_d;
      oClickCol <= ccol_d;
      oClickRow <= crow_d;
      lcol_q    <= lcol_d;
      lrow_q    <= lrow_d;
    end
  end

endmodule

// File: tb/tb_chimp_grid_click.sv
// Bench for chimp_grid_click: press-mode and release-mode DUTs
// share one stimulus stream and are checked against a model.
module tb_chimp_grid_click;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [9:0] mx = '0;
  logic [8:0] my = '0;
  logic       btn = 1'b0;

  logic       d0_hv, d0_click, d0_miss, d0_cancel, d0_busy;
  logic [2:0] d0_hc, d0_hr, d0_ccol, d0_crow;
  logic       d1_hv, d1_click, d1_miss, d1_cancel, d1_busy;
  logic [2:0] d1_hc, d1_hr, d1_ccol, d1_crow;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  chimp_grid_click #(.RELEASE_MODE(0)) dut0 (
    .clk(clk), .iReset(rst_n), .iEnable(en),
    .iMouseX(mx), .iMouseY(my), .iButton(btn),
    .oHoverValid(d0_hv), .oHoverCol(d0_hc),
    .oHoverRow(d0_hr), .oClick(d0_click),
    .oClickCol(d0_ccol), .oClickRow(d0_crow),
    .oMiss(d0_miss), .oCancel(d0_cancel),
    .oBusy(d0_busy)
  );

  chimp_grid_click #(.RELEASE_MODE(1)) dut1 (
    .clk(clk), .iReset(rst_n), .iEnable(en),
    .iMouseX(mx), .iMouseY(my), .iButton(btn),
    .oHoverValid(d1_hv), .oHoverCol(d1_hc),
    .oHoverRow(d1_hr), .oClick(d1_click),
    .oClickCol(d1_ccol), .oClickRow(d1_crow),
    .oMiss(d1_miss), .oCancel(d1_cancel),
    .oBusy(d1_busy)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] st;
    logic       click, miss, cancel;
    logic [2:0] ccol, crow, lcol, lrow;
  } mdl_t;

  function automatic int axis(int c, int org, int span,
                              int pitch, int n);
    if (c < org) return -1;
    if ((c - org) / pitch >= n) return -1;
    if ((c - org) % pitch >= span) return -1;
    return (c - org) / pitch;
  endfunction

  function automatic int ax(int c);
    return axis(c, 17, 20, 37, 8);
  endfunction

  function automatic int ay(int c);
    return axis(c, 8, 20, 28, 8);
  endfunction

  // st: 0 waiting for press, 1 waiting release (armed),
  // 2 waiting release (pulse already given)
  function automatic mdl_t step(mdl_t s, bit rm, bit rise,
                                bit fall, bit e, int c, int r);
    mdl_t n;
    bit v;
    n = s;
    n.click = 0;
    n.miss = 0;
    n.cancel = 0;
    v = (c >= 0) && (r >= 0);
    if (s.st == 2'd0) begin
      if (rise && e) begin
        if (!v) begin
          n.miss = 1;
          n.st = 2'd2;
        end else if (rm) begin
          n.lcol = 3'(c);
          n.lrow = 3'(r);
          n.st = 2'd1;
        end else begin
          n.click = 1;
          n.ccol = 3'(c);
          n.crow = 3'(r);
          n.st = 2'd2;
        end
      end
    end else if (fall) begin
      if (s.st == 2'd1) begin
        if (v && 3'(c) == s.lcol && 3'(r) == s.lrow) begin
          n.click = 1;
          n.ccol = s.lcol;
          n.crow = s.lrow;
        end else begin
          n.cancel = 1;
        end
      end
      n.st = 2'd0;
    end
    return n;
  endfunction

  int   hx0, hx1, hy0, hy1;
  logic hb0, hb1, hb2;
  mdl_t md0, md1;
  logic ehv;
  logic [2:0] ehc, ehr;

  // history of sampled inputs; effects appear two/three edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hx0 <= 0; hx1 <= 0; hy0 <= 0; hy1 <= 0;
      hb0 <= 0; hb1 <= 0; hb2 <= 0;
      md0 <= '0; md1 <= '0;
      ehv <= 0; ehc <= '0; ehr <= '0;
    end else begin
      hx0 <= int'(mx); hy0 <= int'(my);
      hx1 <= hx0;      hy1 <= hy0;
      hb0 <= btn; hb1 <= hb0; hb2 <= hb1;
      ehv <= (ax(hx0) >= 0) && (ay(hy0) >= 0);
      ehc <= (ax(hx0) >= 0 && ay(hy0) >= 0) ? 3'(ax(hx0)) : 3'd0;
      ehr <= (ax(hx0) >= 0 && ay(hy0) >= 0) ? 3'(ay(hy0)) : 3'd0;
      md0 <= step(md0, 1'b0, hb1 & ~hb2, ~hb1 & hb2, en,
                  ax(hx1), ay(hy1));
      md1 <= step(md1, 1'b1, hb1 & ~hb2, ~hb1 & hb2, en,
                  ax(hx1), ay(hy1));
    end
  end

  // ---------------- tests ----------------
  task automatic settle(int n);
    btn = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    mx = 10'd20; my = 9'd10; btn = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({d0_hv, d0_hc, d0_hr, d0_click, d0_ccol, d0_crow,
         d0_miss, d0_cancel, d0_busy} !== '0) begin
      bad++;
      $display("FAIL reset_d0 got=%b want=0",
        {d0_hv, d0_hc, d0_hr, d0_click, d0_ccol, d0_crow,
         d0_miss, d0_cancel, d0_busy});
    end
    total++;
    if ({d1_hv, d1_hc, d1_hr, d1_click, d1_ccol, d1_crow,
         d1_miss, d1_cancel, d1_busy} !== '0) begin
      bad++;
      $display("FAIL reset_d1 got=%b want=0",
        {d1_hv, d1_hc, d1_hr, d1_click, d1_ccol, d1_crow,
         d1_miss, d1_cancel, d1_busy});
    end
    btn = 0;
    rst_n = 1;
    settle(4);
  endtask

  task automatic test_press_hold;
    int clicks, lat, other;
    clicks = 0; lat = -1; other = 0;
    mx = 10'd20; my = 9'd10; en = 1;
    btn = 1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (d0_click) begin clicks++; lat = i; end
      if (d0_miss || d0_cancel) other++;
      total++;
      if (d0_busy !== (i >= 3)) begin
        bad++;
        $display("FAIL hold_busy cyc=%0d got=%b want=%b",
                 i, d0_busy, i >= 3);
      end
    end
    btn = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (d0_click) clicks++;
      if (d0_miss || d0_cancel) other++;
      total++;
      if (d0_busy !== (i < 3)) begin
        bad++;
        $display("FAIL release_busy cyc=%0d got=%b want=%b",
                 i, d0_busy, i < 3);
      end
    end
    total++;
    if (clicks != 1 || lat != 3) begin
      bad++;
      $display("FAIL hold_click got n=%0d lat=%0d want n=1 lat=3",
               clicks, lat);
    end
    total++;
    if (other != 0 || d0_ccol !== 3'd0 || d0_crow !== 3'd0) begin
      bad++;
      $display("FAIL hold_misc got other=%0d col=%0d row=%0d want 0",
               other, d0_ccol, d0_crow);
    end
  endtask

  task automatic test_boundaries;
    int px[6] = '{17, 36, 37, 16, 290, 296};
    int py[6] = '{8, 27, 8, 8, 210, 210};
    int ph[6] = '{1, 1, 0, 0, 1, 0};
    int pc[6] = '{0, 0, 0, 0, 7, 7};
    for (int t = 0; t < 6; t++) begin
      int nc, nm, col, row;
      nc = 0; nm = 0; col = -1; row = -1;
      mx = 10'(px[t]); my = 9'(py[t]);
      btn = 1;
      repeat (6) begin
        @(negedge clk);
        if (d0_click) begin
          nc++; col = int'(d0_ccol); row = int'(d0_crow);
        end
        if (d0_miss) nm++;
      end
      settle(6);
      total++;
      if (nc != ph[t] || nm != 1 - ph[t]) begin
        bad++;
        $display("FAIL bound(%0d,%0d) got click=%0d miss=%0d want %0d/%0d",
                 px[t], py[t], nc, nm, ph[t], 1 - ph[t]);
      end
      if (ph[t] == 1) begin
        total++;
        if (col != pc[t] || row != pc[t]) begin
          bad++;
          $display("FAIL bound_cell(%0d,%0d) got %0d,%0d want %0d,%0d",
                   px[t], py[t], col, row, pc[t], pc[t]);
        end
      end
    end
  endtask

  task automatic test_hover_sweep;
    int nvalid;
    nvalid = 0;
    btn = 0; my = 9'd40;
    for (int x = 0; x <= 321; x++) begin
      int k;
      bit v;
      mx = 10'(x);
      @(negedge clk);
      if (x >= 1) begin
        k = ax(x - 1);
        v = (k >= 0);
        if (d0_hv) nvalid++;
        total++;
        if (d0_hv !== v ||
            d0_hc !== (v ? 3'(k) : 3'd0) ||
            d0_hr !== (v ? 3'd1 : 3'd0)) begin
          bad++;
          $display("FAIL hover x=%0d got v=%b c=%0d r=%0d want v=%b c=%0d",
                   x - 1, d0_hv, d0_hc, d0_hr, v, v ? k : 0);
        end
      end
    end
    total++;
    if (nvalid != 160) begin
      bad++;
      $display("FAIL hover_count got=%0d want=160", nvalid);
    end
  endtask

  task automatic test_release_mode;
    int nc, nx, lat, col, row;
    nc = 0; nx = 0; lat = -1; col = -1; row = -1;
    mx = 10'd60; my = 9'd40; btn = 1;
    repeat (5) @(negedge clk);
    total++;
    if (d1_busy !== 1'b1 || d1_click !== 1'b0) begin
      bad++;
      $display("FAIL armed got busy=%b click=%b want 1/0",
               d1_busy, d1_click);
    end
    btn = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (d1_click) begin
        nc++; lat = i; col = int'(d1_ccol); row = int'(d1_crow);
      end
      if (d1_cancel) nx++;
    end
    total++;
    if (nc != 1 || nx != 0 || lat != 3 || col != 1 || row != 1) begin
      bad++;
      $display("FAIL rel_same got n=%0d c=%0d lat=%0d cell=%0d,%0d want 1,0,3,1,1",
               nc, nx, lat, col, row);
    end
    nc = 0; nx = 0;
    btn = 1;
    repeat (5) @(negedge clk);
    mx = 10'd100; btn = 0;
    repeat (6) begin
      @(negedge clk);
      if (d1_click) nc++;
      if (d1_cancel) nx++;
    end
    total++;
    if (nc != 0 || nx != 1) begin
      bad++;
      $display("FAIL rel_diff got click=%0d cancel=%0d want 0/1",
               nc, nx);
    end
  endtask

  task automatic test_enable;
    int np, nc;
    np = 0; nc = 0;
    en = 0; mx = 10'd20; my = 9'd10; btn = 1;
    repeat (6) begin
      @(negedge clk);
      if (d0_click || d0_miss || d1_cancel || d1_click ||
          d0_busy || d1_busy) np++;
    end
    settle(6);
    total++;
    if (np != 0) begin
      bad++;
      $display("FAIL enable_off got active=%0d want 0", np);
    end
    en = 1; btn = 1;
    repeat (6) begin
      @(negedge clk);
      if (d0_click) nc++;
    end
    btn = 0;
    repeat (6) begin
      @(negedge clk);
      if (d1_click) nc++;
    end
    total++;
    if (nc != 2) begin
      bad++;
      $display("FAIL enable_on got clicks=%0d want 2", nc);
    end
  endtask

  task automatic test_reset_armed;
    int nc;
    nc = 0;
    mx = 10'd20; my = 9'd10; btn = 1;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if ({d1_click, d1_ccol, d1_crow, d1_cancel, d1_busy,
         d1_hv, d1_miss} !== '0) begin
      bad++;
      $display("FAIL rst_armed got=%b want=0",
        {d1_click, d1_ccol, d1_crow, d1_cancel, d1_busy,
         d1_hv, d1_miss});
    end
    @(negedge clk);
    btn = 0;
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      if (d1_click || d1_cancel || d1_miss) nc++;
    end
    total++;
    if (nc != 0) begin
      bad++;
      $display("FAIL rst_drop got pulses=%0d want 0", nc);
    end
    btn = 1;
    repeat (4) @(negedge clk);
    btn = 0;
    repeat (6) begin
      @(negedge clk);
      if (d1_click && d1_ccol == 3'd0 && d1_crow == 3'd0) nc++;
    end
    total++;
    if (nc != 1) begin
      bad++;
      $display("FAIL rst_recover got clicks=%0d want 1", nc);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      total++;
      if ({d0_hv, d0_hc, d0_hr} !== {ehv, ehc, ehr}) begin
        bad++;
        $display("FAIL rnd_hover i=%0d got=%h want=%h", i,
                 {d0_hv, d0_hc, d0_hr}, {ehv, ehc, ehr});
      end
      total++;
      if ({d0_click, d0_miss, d0_cancel, d0_ccol, d0_crow,
           d0_busy} !== {md0.click, md0.miss, md0.cancel,
           md0.ccol, md0.crow, md0.st != 2'd0}) begin
        bad++;
        $display("FAIL rnd_m0 i=%0d got=%b want=%b", i,
          {d0_click, d0_miss, d0_cancel, d0_ccol, d0_crow, d0_busy},
          {md0.click, md0.miss, md0.cancel, md0.ccol, md0.crow,
           md0.st != 2'd0});
      end
      total++;
      if ({d1_click, d1_miss, d1_cancel, d1_ccol, d1_crow,
           d1_busy} !== {md1.click, md1.miss, md1.cancel,
           md1.ccol, md1.crow, md1.st != 2'd0}) begin
        bad++;
        $display("FAIL rnd_m1 i=%0d got=%b want=%b", i,
          {d1_click, d1_miss, d1_cancel, d1_ccol, d1_crow, d1_busy},
          {md1.click, md1.miss, md1.cancel, md1.ccol, md1.crow,
           md1.st != 2'd0});
      end
      total++;
      if (int'(d1_click) + int'(d1_miss) + int'(d1_cancel) > 1) begin
        bad++;
        $display("FAIL rnd_onehot i=%0d got=%b%b%b want at most one",
                 i, d1_click, d1_miss, d1_cancel);
      end
      if ($urandom_range(0, 3) == 0) begin
        mx = 10'($urandom_range(0, 330));
        my = 9'($urandom_range(0, 240));
      end
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      if ($urandom_range(0, 19) == 0) en = ~en;
    end
    en = 1;
    settle(6);
  endtask

  initial begin
    test_reset();
    test_press_hold();
    settle(4);
    test_boundaries();
    test_hover_sweep();
    settle(4);
    test_release_mode();
    settle(4);
    test_enable();
    settle(4);
    test_reset_armed();
    settle(4);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
